// File: rtl/dual_fetch_unit.sv
// rtl/dual_fetch_unit.sv - dual-issue fetch front end: PC generation, imem handshake, pair FIFO
// Issues one pair request at a time and presents the buffered head pair to IF/ID.
module dual_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [7:0]  RESET_PC = 8'h00
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [7:0]               redirect_pc,
   output logic                     imem_req,
   output logic [7:0]               imem_addr,
   input  logic                     imem_ready,
   input  logic                     imem_rvalid,
   input  logic [31:0]              imem_rdata1,
   input  logic [31:0]              imem_rdata2,
   output logic [7:0]               pc_out,
   output logic [31:0]              instruction1,
   output logic [31:0]              instruction2,
   output logic                     fetch_valid,
   output logic [$clog2(DEPTH):0]   buf_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [7:0]      r_fetch_pc;
   logic [7:0]      r_req_pc;
   logic [7:0]      r_pc_mem [DEPTH];
   logic [31:0]     r_i1_mem [DEPTH];
   logic [31:0]     r_i2_mem [DEPTH];
   logic [AW-1:0]   r_rd_ptr;
   logic [AW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic            w_has_room;
   logic            w_issue;
   logic            w_push;
   logic            w_pop;

   assign w_has_room = (r_count < CW'(DEPTH));
   assign w_issue    = imem_req && imem_ready;
   assign w_pop      = fetch_valid && !stall && !redirect;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A response that coincides with a redirect belongs to the old path and is dropped.
   always_comb begin
      w_next   = r_state;
      imem_req = 1'b0;
      w_push   = 1'b0;
      case (r_state)
         S_IDLE: begin
            imem_req = w_has_room && !redirect && !reset;
            if (imem_req && imem_ready) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               w_push = !redirect;
               w_next = S_IDLE;
            end else if (redirect) begin
               w_next = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem_rvalid) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= 8'h00;
      end else if (redirect) begin
         r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
         r_req_pc   <= r_fetch_pc;
         r_fetch_pc <= r_fetch_pc + 8'd2;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own width.
   always_ff @(posedge clk) begin
      if (reset || redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_pc_mem[r_wr_ptr] <= r_req_pc;
            r_i1_mem[r_wr_ptr] <= imem_rdata1;
            r_i2_mem[r_wr_ptr] <= imem_rdata2;
            r_wr_ptr           <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign imem_addr    = r_fetch_pc;
   assign fetch_valid  = (r_count != '0);
   assign buf_count    = r_count;
   assign pc_out       = fetch_valid ? r_pc_mem[r_rd_ptr] : 8'h00;
   assign instruction1 = fetch_valid ? r_i1_mem[r_rd_ptr] : 32'h0;
   assign instruction2 = fetch_valid ? r_i2_mem[r_rd_ptr] : 32'h0;

endmodule

// File: tb/tb_dual_fetch_unit.sv
// tb/tb_dual_fetch_unit.sv - randomized scoreboard bench for dual_fetch_unit
// Expected stream: after reset/redirect to P, pairs P, P+2, ... each {pc, mem[pc], mem[pc+1]}.
module tb_dual_fetch_unit;

   localparam int         DEPTH    = 4;
   localparam logic [7:0] RESET_PC = 8'h00;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata1;
   logic [31:0] imem_rdata2;
   logic [7:0]  pc_out;
   logic [31:0] instruction1;
   logic [31:0] instruction2;
   logic        fetch_valid;
   logic [$clog2(DEPTH):0] buf_count;

   dual_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
      .imem_rdata1(imem_rdata1), .imem_rdata2(imem_rdata2),
      .pc_out(pc_out), .instruction1(instruction1), .instruction2(instruction2),
      .fetch_valid(fetch_valid), .buf_count(buf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [256];
   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [71:0] q[$];
   logic [7:0]  gen_pc;
   logic [7:0]  exp_addr;
   bit          out_busy = 1'b0;
   bit          prev_rst = 1'b0;

   task automatic topup();
      while (q.size() < 16) begin
         q.push_back({gen_pc, mem[gen_pc], mem[gen_pc + 8'd1]});
         gen_pc = gen_pc + 8'd2;
      end
   endtask

   task automatic refill(input logic [7:0] target);
      q.delete();
      gen_pc   = target;
      exp_addr = target;
      topup();
   endtask

   always @(negedge clk) begin
      if (prev_rst) begin
         check("post_reset_outputs", {fetch_valid, buf_count, pc_out, instruction1, instruction2}, '0);
      end
      if (reset) begin
         check("reset_req", imem_req, 1'b0);
         refill(RESET_PC);
         out_busy = 1'b0;
      end else begin
         if (fetch_valid) begin
            check("head_pair", {pc_out, instruction1, instruction2}, q[0]);
            if (!stall && !redirect) begin
               void'(q.pop_front());
               topup();
            end
         end else begin
            check("empty_outputs", {buf_count, pc_out, instruction1, instruction2}, '0);
         end
         check("count_range", (buf_count <= DEPTH), 1'b1);
         if (redirect) check("req_on_redirect", imem_req, 1'b0);
         if (imem_req && imem_ready) begin
            check("one_outstanding", out_busy, 1'b0);
            check("req_addr", imem_addr, exp_addr);
            exp_addr = exp_addr + 8'd2;
            out_busy = 1'b1;
         end else if (imem_rvalid) begin
            out_busy = 1'b0;
         end
         if (redirect) refill(redirect_pc);
      end
      prev_rst = reset;
   end

   // ---------------- memory model and stimulus ----------------
   int ready_pct, stall_pct, redir_pct, lat_min, lat_max;
   bit force_stale;
   bit pend;
   logic [7:0] pend_addr;
   int pend_t;

   task automatic step();
      bit hs;
      logic [7:0] a;
      @(negedge clk);
      hs = imem_req && imem_ready;
      a  = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata1 = $urandom;
      imem_rdata2 = $urandom;
      if (hs) begin
         pend      = 1'b1;
         pend_addr = a;
         pend_t    = $urandom_range(lat_max, lat_min);
      end
      if (pend) begin
         pend_t--;
         if (pend_t == 0) begin
            pend        = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata1 = force_stale ? 32'hDEAD_BEEF : mem[pend_addr];
            imem_rdata2 = force_stale ? 32'hDEAD_BEEF : mem[pend_addr + 8'd1];
         end
      end
      imem_ready  = ($urandom_range(99, 0) < ready_pct);
      stall       = ($urandom_range(99, 0) < stall_pct);
      redirect    = ($urandom_range(99, 0) < redir_pct);
      redirect_pc = 8'($urandom);
   endtask

   task automatic wait_just_issued(input string name);
      int n;
      n = 0;
      while (!(pend && pend_t == 2) && n < 30) begin
         step();
         n++;
      end
      check(name, (pend && pend_t == 2), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
      ready_pct = 100; stall_pct = 0; redir_pct = 0; lat_min = 1; lat_max = 1;
      force_stale = 1'b0; pend = 1'b0; pend_addr = 8'h00; pend_t = 0;
      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata1 = '0; imem_rdata2 = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      imem_ready = 1'b1;

      repeat (30) step();

      stall_pct = 100;
      repeat (10) step();
      check("stall_full_count", buf_count, DEPTH);
      check("stall_full_req", imem_req, 1'b0);
      stall_pct = 0;
      repeat (20) step();

      lat_min = 3; lat_max = 3;
      wait_just_issued("wait_issue_a");
      redirect = 1'b1; redirect_pc = 8'h40;
      step();
      check("redirect_valid", fetch_valid, 1'b0);
      check("redirect_count", buf_count, 0);
      repeat (20) step();

      lat_min = 2; lat_max = 2;
      n = 0;
      while (!imem_rvalid && n < 30) begin
         step();
         n++;
      end
      check("wait_rvalid", imem_rvalid, 1'b1);
      redirect = 1'b1; redirect_pc = 8'h20;
      step();
      check("redirect_rvalid_count", buf_count, 0);

      lat_min = 3; lat_max = 3;
      wait_just_issued("wait_issue_b");
      redirect = 1'b1; redirect_pc = 8'h10;
      step();
      redirect = 1'b1; redirect_pc = 8'h80;
      repeat (20) step();

      lat_min = 1; lat_max = 2; stall_pct = 30;
      redirect = 1'b1; redirect_pc = 8'hFC;
      repeat (40) step();

      lat_min = 3; lat_max = 3; stall_pct = 0;
      wait_just_issued("wait_issue_c");
      reset = 1'b1; imem_ready = 1'b0; ready_pct = 0; force_stale = 1'b1;
      step();
      reset = 1'b0;
      check("mid_reset_outputs", {fetch_valid, buf_count, pc_out, instruction1, instruction2}, '0);
      step();
      step();
      check("late_resp_ignored", {fetch_valid, buf_count, pc_out, instruction1, instruction2}, '0);
      force_stale = 1'b0; ready_pct = 100;
      repeat (20) step();

      ready_pct = 75; stall_pct = 30; redir_pct = 3; lat_min = 1; lat_max = 3;
      repeat (1500) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
